// File: rtl/serv_rf_pkg.sv
// Shared types for the buffered SERV register-file RAM wrapper: buffer entry,
// port-operation encoding, the default macro depth and a parity helper.
package serv_rf_pkg;

   // Entries are sized for the widest legal configuration; narrower builds zero-extend.
   localparam int RF_AW_MAX = 16;
   localparam int RF_DW_MAX = 8;

   typedef struct packed {
      logic [RF_AW_MAX-1:0] addr;
      logic [RF_DW_MAX-1:0] data;
   } wbuf_entry_t;

   typedef enum logic [1:0] {
      PORT_IDLE  = 2'd0,
      PORT_READ  = 2'd1,
      PORT_DRAIN = 2'd2,
      PORT_FULL  = 2'd3
   } port_op_e;

   function automatic int rf_depth(input int width, input int csr_regs);
      return 32 * (32 + csr_regs) / width;
   endfunction

   function automatic logic even_par(input logic [RF_DW_MAX-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/serv_rf_ram_wbuf_chk.sv
// Simulation checks for the buffered RF wrapper: addresses in range and
// buffer entries free of stray bits above the configured widths.
module serv_rf_ram_wbuf_chk
   import serv_rf_pkg::*;
#(
   parameter int width = 2,
   parameter int depth = 576,
   parameter int AW    = 10
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   input logic                 wen_i,
   input logic [AW-1:0]        waddr_i,
   input logic                 ren_i,
   input logic [AW-1:0]        raddr_i,
   input wbuf_entry_t          oldest_i,
   input logic [RF_DW_MAX-1:0] hit_data_i
);

   a_waddr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      wen_i |-> (32'(waddr_i) < depth));
   a_raddr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ren_i |-> (32'(raddr_i) < depth));
   a_oldest_clean: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((oldest_i.data >> width) == RF_DW_MAX'(0)) && (oldest_i.addr < RF_AW_MAX'(depth)));
   a_hit_clean: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (hit_data_i >> width) == RF_DW_MAX'(0));

endmodule

// File: rtl/serv_rf_wbuf.sv
// Write buffer: shift FIFO (slot 0 oldest) with a newest-match address compare
// against every valid slot, evaluated on the current (pre-push) contents.
module serv_rf_wbuf
   import serv_rf_pkg::*;
#(
   parameter int WBUF_DEPTH = 2,
   parameter int AW         = 10,
   parameter int CW         = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  wbuf_entry_t          push_entry_i,
   input  logic                 pop_i,
   input  logic [AW-1:0]        raddr_i,
   output logic [CW-1:0]        count_o,
   output wbuf_entry_t          oldest_o,
   output logic                 hit_o,
   output logic [RF_DW_MAX-1:0] hit_data_o
);

   wbuf_entry_t   entry_q [WBUF_DEPTH];
   wbuf_entry_t   entry_d [WBUF_DEPTH];
   logic [CW-1:0] count_q, count_d, widx_s;

   // FIFO next state: pop shifts toward slot 0, push lands behind the survivors
   always_comb begin
      entry_d = entry_q;
      widx_s  = count_q;
      if (pop_i) begin
         for (int i = 0; i < WBUF_DEPTH - 1; i++) begin
            entry_d[i] = entry_q[i+1];
         end
         entry_d[WBUF_DEPTH-1] = '0;
         widx_s = count_q - CW'(1);
      end else begin
         widx_s = count_q;
      end
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         entry_d[i] = (push_i && (CW'(i) == widx_s)) ? push_entry_i : entry_d[i];
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
   end

   // Later slots are younger, so the last match in slot order wins
   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         if ((CW'(i) < count_q) && (entry_q[i].addr == RF_AW_MAX'(raddr_i))) begin
            hit_o      = 1'b1;
            hit_data_o = entry_q[i].data;
         end else begin
            hit_o      = hit_o;
            hit_data_o = hit_data_o;
         end
      end
   end

   // Buffer state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         entry_q <= entry_d;
      end
   end

   assign count_o  = count_q;
   assign oldest_o = entry_q[0];

endmodule

// File: rtl/serv_rf_ram_wbuf.sv
// SERV RF wrapper: single-port macro behind a write buffer; reads win the port,
// writes drain on idle cycles or when the buffer is full. RF_PARITY_EN adds parity.
module serv_rf_ram_wbuf
   import serv_rf_pkg::*;
#(
   parameter int width      = 2,
   parameter int csr_regs   = 4,
   parameter int depth      = rf_depth(width, csr_regs),
   parameter int WBUF_DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [$clog2(depth)-1:0] i_waddr,
   input  logic [width-1:0]         i_wdata,
   input  logic                     i_wen,
   output logic                     o_wready,
   input  logic [$clog2(depth)-1:0] i_raddr,
   input  logic                     i_ren,
   output logic                     o_rready,
   output logic [width-1:0]         o_rdata,
   output logic                     o_rvalid,
   output logic                     o_rerr
);

   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(WBUF_DEPTH + 1);
`ifdef RF_PARITY_EN
   localparam int MW = width + 1;
`else
   localparam int MW = width;
`endif

   logic [CW-1:0]        count_s;
   wbuf_entry_t          oldest_s, push_entry_s;
   logic                 hit_s, full_s, push_s, pop_s, mem_ce_s, mem_we_s;
   logic [RF_DW_MAX-1:0] hit_data_s;
   port_op_e             op_s;
   logic [AW-1:0]        mem_addr_s;
   logic [MW-1:0]        mem_wdata_s, mem_rword_s;
   logic [MW-1:0]        mem_q [depth];
   logic [width-1:0]     rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;

   assign full_s       = (count_s == CW'(WBUF_DEPTH));
   assign o_wready     = ~full_s;
   assign o_rready     = ~full_s;
   assign push_s       = i_wen & ~full_s;
   assign push_entry_s = '{addr: RF_AW_MAX'(i_waddr), data: RF_DW_MAX'(i_wdata)};

   serv_rf_wbuf #(.WBUF_DEPTH(WBUF_DEPTH), .AW(AW), .CW(CW)) u_wbuf (
      .clk_i(i_clk), .rst_ni(i_rst_n), .push_i(push_s), .push_entry_i(push_entry_s),
      .pop_i(pop_s), .raddr_i(i_raddr), .count_o(count_s), .oldest_o(oldest_s),
      .hit_o(hit_s), .hit_data_o(hit_data_s)
   );

   // Port arbitration: full buffer beats reads, reads beat opportunistic drains
   always_comb begin
      op_s = PORT_IDLE;
      if (full_s) begin
         op_s = PORT_FULL;
      end else if (i_ren) begin
         op_s = PORT_READ;
      end else if (count_s != CW'(0)) begin
         op_s = PORT_DRAIN;
      end else begin
         op_s = PORT_IDLE;
      end
   end

   // Macro control derived from the selected port operation
   always_comb begin
      mem_ce_s   = 1'b0;
      mem_we_s   = 1'b0;
      pop_s      = 1'b0;
      mem_addr_s = oldest_s.addr[AW-1:0];
      case (op_s)
         PORT_READ: begin
            mem_ce_s   = 1'b1;
            mem_addr_s = i_raddr;
         end
         PORT_DRAIN, PORT_FULL: begin
            mem_ce_s = 1'b1;
            mem_we_s = 1'b1;
            pop_s    = 1'b1;
         end
         PORT_IDLE: mem_ce_s = 1'b0;
         default:   mem_ce_s = 1'b0;
      endcase
   end

`ifdef RF_PARITY_EN
   assign mem_wdata_s = {even_par(RF_DW_MAX'(oldest_s.data[width-1:0])), oldest_s.data[width-1:0]};
`else
   assign mem_wdata_s = oldest_s.data[width-1:0];
`endif
   assign mem_rword_s = mem_q[mem_addr_s];

   // Macro storage: contents survive reset
   always_ff @(posedge i_clk) begin
      if (mem_ce_s && mem_we_s) begin
         mem_q[mem_addr_s] <= mem_wdata_s;
      end
   end

   // Read result: forwarded buffer data overrides the macro word
   always_comb begin
      rvalid_d = (op_s == PORT_READ);
      rdata_d  = rdata_q;
      if (op_s == PORT_READ) begin
         rdata_d = hit_s ? hit_data_s[width-1:0] : mem_rword_s[width-1:0];
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Read output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign o_rdata  = rdata_q;
   assign o_rvalid = rvalid_q;

`ifdef RF_PARITY_EN
   logic rerr_q, rerr_d;

   assign rerr_d = (op_s == PORT_READ) && !hit_s && (^mem_rword_s);

   // Parity error flag, pulsed alongside o_rvalid for macro-sourced reads
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rerr_q <= 1'b0;
      end else begin
         rerr_q <= rerr_d;
      end
   end

   assign o_rerr = rerr_q;
`else
   assign o_rerr = 1'b0;
`endif

   serv_rf_ram_wbuf_chk #(.width(width), .depth(depth), .AW(AW)) u_chk (
      .clk_i(i_clk), .rst_ni(i_rst_n), .wen_i(i_wen), .waddr_i(i_waddr),
      .ren_i(i_ren), .raddr_i(i_raddr), .oldest_i(oldest_s), .hit_data_i(hit_data_s)
   );

endmodule

// File: tb/tb_serv_rf_ram_wbuf.sv
// Directed bench for serv_rf_ram_wbuf (width=2, csr_regs=4, WBUF_DEPTH=2).
module tb_serv_rf_ram_wbuf;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] waddr = '0, raddr = '0;
   logic [1:0] wdata = '0;
   logic       wen = 1'b0, ren = 1'b0;
   logic       wready, rready, rvalid, rerr;
   logic [1:0] rdata;
   int         checks = 0, errors = 0;

   serv_rf_ram_wbuf #(.width(2), .csr_regs(4), .WBUF_DEPTH(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
      .o_wready(wready), .i_raddr(raddr), .i_ren(ren), .o_rready(rready),
      .o_rdata(rdata), .o_rvalid(rvalid), .o_rerr(rerr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [9:0] wa, input logic [1:0] wd,
                        input logic re, input logic [9:0] ra);
      wen = we; waddr = wa; wdata = wd; ren = re; raddr = ra;
   endtask

   task automatic test_reset();
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0);
      tick(); tick();
      checks++; if (rdata !== 2'd0) begin errors++; $display("FAIL reset_rdata got %0d exp 0", rdata); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b exp 0", rvalid); end
      checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL reset_rerr got %0b exp 0", rerr); end
      checks++; if (wready !== 1'b1) begin errors++; $display("FAIL reset_wready got %0b exp 1", wready); end
      checks++; if (rready !== 1'b1) begin errors++; $display("FAIL reset_rready got %0b exp 1", rready); end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_drain();
      drive(1'b1, 10'd5, 2'd1, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd5); tick();
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL wd_rvalid got %0b exp 1", rvalid); end
      checks++; if (rdata !== 2'd1) begin errors++; $display("FAIL wd_rdata got %0d exp 1", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wd_rvalid_drop got %0b exp 0", rvalid); end
      checks++; if (rdata !== 2'd1) begin errors++; $display("FAIL wd_rdata_hold got %0d exp 1", rdata); end
   endtask

   task automatic test_forward();
      drive(1'b1, 10'd7, 2'd1, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
      drive(1'b1, 10'd7, 2'd2, 1'b1, 10'd7); tick();
      checks++; if (rdata !== 2'd1) begin errors++; $display("FAIL fwd_same_cycle got %0d exp 1", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd7); tick();
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL fwd_rvalid got %0b exp 1", rvalid); end
      checks++; if (rdata !== 2'd2) begin errors++; $display("FAIL fwd_data got %0d exp 2", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd7); tick();
      checks++; if (rdata !== 2'd2) begin errors++; $display("FAIL fwd_macro got %0d exp 2", rdata); end
   endtask

   task automatic test_full_stall();
      logic [9:0] exp_v;
      exp_v = 10'b1111111011;
      for (int i = 0; i < 10; i++) begin
         drive(i < 2, (i == 0) ? 10'd10 : 10'd11, (i == 0) ? 2'd3 : 2'd1, 1'b1, 10'd5);
         tick();
         checks++;
         if (rvalid !== exp_v[i]) begin errors++; $display("FAIL stall_rvalid[%0d] got %0b exp %0b", i, rvalid, exp_v[i]); end
         if (i == 1) begin
            checks++; if (wready !== 1'b0) begin errors++; $display("FAIL full_wready got %0b exp 0", wready); end
            checks++; if (rready !== 1'b0) begin errors++; $display("FAIL full_rready got %0b exp 0", rready); end
         end
         if (i == 2) begin
            checks++; if (rready !== 1'b1) begin errors++; $display("FAIL resume_rready got %0b exp 1", rready); end
         end
      end
      checks++; if (rdata !== 2'd1) begin errors++; $display("FAIL stall_rdata got %0d exp 1", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd10); tick();
      checks++; if (rdata !== 2'd3) begin errors++; $display("FAIL drain_a10 got %0d exp 3", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd11); tick();
      checks++; if (rdata !== 2'd1) begin errors++; $display("FAIL drain_a11 got %0d exp 1", rdata); end
   endtask

   task automatic test_newest();
      drive(1'b1, 10'd20, 2'd1, 1'b1, 10'd5); tick();
      drive(1'b1, 10'd20, 2'd3, 1'b1, 10'd20); tick();
      checks++; if (rdata !== 2'd1) begin errors++; $display("FAIL newest_hidden got %0d exp 1", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd20); tick();
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL newest_stall got %0b exp 0", rvalid); end
      tick();
      checks++; if (rdata !== 2'd3) begin errors++; $display("FAIL newest_fwd got %0d exp 3", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd20); tick();
      checks++; if (rdata !== 2'd3) begin errors++; $display("FAIL newest_macro got %0d exp 3", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
   endtask

   task automatic test_reset_mid_drain();
      drive(1'b1, 10'd5, 2'd2, 1'b1, 10'd10); tick();
      drive(1'b1, 10'd10, 2'd1, 1'b1, 10'd10); tick();
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL pre_rst_wready got %0b exp 0", wready); end
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd10);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL arst_rvalid got %0b exp 0", rvalid); end
      checks++; if (rdata !== 2'd0) begin errors++; $display("FAIL arst_rdata got %0d exp 0", rdata); end
      checks++; if (wready !== 1'b1) begin errors++; $display("FAIL arst_wready got %0b exp 1", wready); end
      tick();
      @(negedge clk); rst_n = 1'b1;
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick(); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd5); tick();
      checks++; if (rdata !== 2'd1) begin errors++; $display("FAIL discard_a5 got %0d exp 1", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd10); tick();
      checks++; if (rdata !== 2'd3) begin errors++; $display("FAIL discard_a10 got %0d exp 3", rdata); end
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
   endtask

   task automatic test_parity();
`ifdef RF_PARITY_EN
      drive(1'b1, 10'd30, 2'd2, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd30); tick();
      checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL par_clean got %0b exp 0", rerr); end
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
      dut.mem_q[30][2] = ~dut.mem_q[30][2];
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd30); tick();
      checks++; if (rerr !== 1'b1 || rvalid !== 1'b1) begin errors++; $display("FAIL par_err got %0b/%0b exp 1/1", rerr, rvalid); end
      drive(1'b1, 10'd30, 2'd1, 1'b0, 10'd0); tick();
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd30); tick();
      checks++; if (rerr !== 1'b0 || rdata !== 2'd1) begin errors++; $display("FAIL par_fwd got %0b/%0d exp 0/1", rerr, rdata); end
`else
      drive(1'b0, 10'd0, 2'd0, 1'b1, 10'd5); tick();
      checks++; if (rerr !== 1'b0 || rvalid !== 1'b1) begin errors++; $display("FAIL rerr_tied got %0b/%0b exp 0/1", rerr, rvalid); end
`endif
      drive(1'b0, 10'd0, 2'd0, 1'b0, 10'd0); tick();
   endtask

   initial begin
      test_reset();
      test_write_drain();
      test_forward();
      test_full_stall();
      test_newest();
      test_reset_mid_drain();
      test_parity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serv_rf_ram_wbuf.md
Name: serv_rf_ram_wbuf

Overview:
- Parametrised successor to the SERV register-file RAM wrapper.
- Drives one single-port synchronous macro: one address, one access per cycle.
- A small write buffer sits in front of the macro, so reads and writes can be presented in the same cycle.
  - Reads take the port first.
  - Buffered writes drain on idle port cycles.
  - Read-after-write hazards are forwarded from the buffer.
- Sits between serv_rf_if and the hard macro in the sky130hd serv flow.

Parameters:
- width, 2, data bits per word; must be 1, 2, 4 or 8.
- csr_regs, 4, number of CSR registers stored in the RF.
- depth, 32*(32+csr_regs)/width, words in the macro.
- WBUF_DEPTH, 2, write-buffer entries; must be 1..4.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_waddr  in  $clog2(depth)  write address.
- i_wdata  in  width  write data.
- i_wen  in  1  write request; accepted when o_wready=1.
- o_wready  out  1  write buffer can accept an entry.
- i_raddr  in  $clog2(depth)  read address.
- i_ren  in  1  read request; accepted when o_rready=1.
- o_rready  out  1  a read can be issued this cycle.
- o_rdata  out  width  read data.
- o_rvalid  out  1  o_rdata valid, one cycle after an accepted read.
- o_rerr  out  1  parity error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - buffer count=0, all entries invalid.
  - o_rdata=0, o_rvalid=0, o_rerr=0.
  - o_wready=1, o_rready=1.
  - Pending writes are discarded. Macro contents are undefined/unchanged.
- Buffer: FIFO of {addr, data}, count 0..WBUF_DEPTH.
  - o_wready = (count != WBUF_DEPTH).
  - o_rready = (count != WBUF_DEPTH).
- Port arbitration, each cycle, as a priority order:
  1. FULL: count==WBUF_DEPTH. Forced drain of the oldest entry; no read is issued.
  2. READ: i_ren && o_rready. Macro read at i_raddr with we=0.
  3. DRAIN: count>0. Macro write of the oldest entry.
  4. IDLE: ce deasserted.
- Write accept:
  - i_wen && o_wready pushes the entry at the clock edge.
  - Push and drain in the same cycle: count is unchanged, FIFO order is preserved.
- Read latency: exactly 1 cycle.
  - o_rvalid pulses 1 in the cycle after an accepted read, otherwise 0.
  - o_rdata holds its last value when o_rvalid=0.
- Forwarding:
  - At read accept, i_raddr is compared against all valid buffer entries.
  - The newest matching entry's data is registered and returned in place of macro data.
  - A write pushed in the same cycle as the read is NOT visible; the read returns older data.
  - A draining entry counts as still buffered for the compare in its drain cycle.
- Same-address writes: both are buffered and drained in order; the last write wins in the macro.
- Addresses >= depth: undefined; this is an assertion in simulation only.

Optional Feature:
- Macro: RF_PARITY_EN.
- Defined:
  - The macro word is width+1 bits; even parity is stored on drain.
  - On a macro-sourced read, o_rerr = parity mismatch, aligned with o_rvalid.
  - Forwarded reads always give o_rerr=0.
- Undefined:
  - The macro word is width bits.
  - o_rerr is tied 0.

Decomposition:
- Package serv_rf_pkg:
  - typedef for the buffer entry {addr, data}.
  - Enum for port op: PORT_IDLE, PORT_READ, PORT_DRAIN, PORT_FULL.
  - Function computing depth from width/csr_regs.
- Sub-module serv_rf_wbuf:
  - The FIFO plus newest-match CAM compare.
  - Outputs: count, oldest entry, hit, hit_data.
- The top level holds arbitration, the macro instance and output registers.

Test Plan (width=2, csr_regs=4, depth=576, WBUF_DEPTH=2):
- Write 0x1@addr 5 with no read; idle 1 cycle; read addr 5 → macro drain in cycle+1; o_rvalid next cycle with o_rdata=0x1.
- Write 0x2@addr 7 and read addr 7 in the same cycle → o_rdata=old value; read addr 7 next cycle → forwarded 0x2 while the entry is still buffered.
- Continuous i_ren for 10 cycles with writes 0x3@10 and 0x1@11 → count=2, o_wready=0, o_rready=0; forced drain; read stalls exactly 1 cycle and then resumes.
- Writes 0x1@20 then 0x3@20 back-to-back; read addr 20 → 0x3 (newest match); after drain, a macro read returns 0x3.
- Two writes buffered, then i_rst_n low mid-drain → count=0, o_rvalid=0, o_rdata=0, o_wready=1 immediately (asynchronous).
- RF_PARITY_EN: force-flip a stored parity bit at addr 30; read addr 30 → o_rerr=1 with o_rvalid; a forwarded read of a buffered entry → o_rerr=0.
